// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path.
// - tx_state_e : TX framing FSM state codes (code names shared with the bench)
// - PAR_*      : parity mode encodings for the uart_tx_top 'parity' parameter
// - has_parity : true when a mode inserts a parity bit
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b011,
    PARITY = 3'b010,
    STOP   = 3'b110,
    DONE   = 3'b111
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  // Only ODD and EVEN add a bit; any other code means no parity bit.
  function automatic logic has_parity(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-low reset
//   tick out one-clk pulse every clk_freq/(BAUD*oversampling_rate) clocks
// The counter free-runs from reset and is never realigned to frame starts,
// so the first bit of a frame may be up to one tick period short.
module uart_baud_tick #(
  parameter int BAUD              = 9600,
  parameter int clk_freq          = 50_000_000,
  parameter int oversampling_rate = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = clk_freq / (BAUD * oversampling_rate);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  // Decoded from a register, so it is a clean single-clock pulse.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: baud tick generator plus framing FSM.
// Frame: start(0), data_wd bits LSB first, optional parity, stop(1).
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   tx_start in   level request, accepted in IDLE on the clock edge
//   din      in   word to send, latched on acceptance
//   tick     out  oversampling tick (observability)
//   tx       out  registered serial line, idles high
//   tx_done  out  sticky frame-complete flag, cleared on next accept
//   tx_busy  out  registered, high while a frame is on the line
module uart_tx_top
  import uart_tx_pkg::*;
#(
  parameter int         BAUD              = 9600,
  parameter int         clk_freq          = 50_000_000,
  parameter int         oversampling_rate = 16,
  parameter int         data_wd           = 8,
  parameter logic [1:0] parity            = PAR_NONE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_start,
  input  logic [data_wd-1:0] din,
  output logic               tick,
  output logic               tx,
  output logic               tx_done,
  output logic               tx_busy
);

  localparam int TCW = (oversampling_rate > 1) ? $clog2(oversampling_rate) : 1;
  localparam int BIW = (data_wd > 1) ? $clog2(data_wd) : 1;
  localparam logic [TCW-1:0] TC_LAST = TCW'(oversampling_rate - 1);
  localparam logic [BIW-1:0] BI_LAST = BIW'(data_wd - 1);
  localparam logic           HAS_PAR = has_parity(parity);

  tx_state_e          state, state_n;
  logic [TCW-1:0]     tick_count, tick_count_n;
  logic [BIW-1:0]     bit_index, bit_index_n;
  logic [data_wd-1:0] shift, shift_n;
  logic               tx_n, busy_n, done_n;
  logic               bit_end;

  uart_baud_tick #(
    .BAUD              (BAUD),
    .clk_freq          (clk_freq),
    .oversampling_rate (oversampling_rate)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign bit_end = tick && (tick_count == TC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tick_count <= '0;
      bit_index  <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      tick_count <= tick_count_n;
      bit_index  <= bit_index_n;
      shift      <= shift_n;
      tx         <= tx_n;
      tx_busy    <= busy_n;
      tx_done    <= done_n;
    end
  end

  always_comb begin
    state_n      = state;
    tick_count_n = tick_count;
    bit_index_n  = bit_index;
    shift_n      = shift;
    done_n       = tx_done;
    tx_n         = 1'b1;
    busy_n       = 1'b0;

    if (tick && (state inside {START, DATA, PARITY, STOP}))
      tick_count_n = tick_count + TCW'(1);

    case (state)
      IDLE: if (tx_start) begin
        shift_n = din;
        done_n  = 1'b0;
        state_n = START;
      end
      START:  if (bit_end) state_n = DATA;
      DATA: if (bit_end) begin
        if (bit_index == BI_LAST) state_n = HAS_PAR ? PARITY : STOP;
        else                      bit_index_n = bit_index + BIW'(1);
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: if (bit_end) begin
        state_n = DONE;
        done_n  = 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Every state entry starts a fresh bit period.
    if (state_n != state) begin
      tick_count_n = '0;
      bit_index_n  = '0;
    end

    // Decode outputs from the next state so the registered tx/tx_busy line
    // up with the state register rather than lagging it by a clock.
    case (state_n)
      START: begin
        tx_n   = 1'b0;
        busy_n = 1'b1;
      end
      DATA: begin
        tx_n   = shift_n[bit_index_n];
        busy_n = 1'b1;
      end
      PARITY: begin
        tx_n   = (parity == PAR_EVEN) ? ^shift_n : ~^shift_n;
        busy_n = 1'b1;
      end
      STOP:    busy_n = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_top.sv
module tb_uart_tx_top;
  import uart_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tick, tx, tx_done, tx_busy;

  logic       tx_start_p = 1'b0;
  logic [7:0] din_p = 8'h00;
  logic       tick_e, tx_e, done_e, busy_e;
  logic       tick_o, tx_o, done_o, busy_o;

  int checks = 0;
  int errors = 0;

  uart_tx_top #(.parity(2'd0)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .din(din),
    .tick(tick), .tx(tx), .tx_done(tx_done), .tx_busy(tx_busy));

  uart_tx_top #(.parity(2'd2)) dut_e (
    .clk(clk), .rst(rst), .tx_start(tx_start_p), .din(din_p),
    .tick(tick_e), .tx(tx_e), .tx_done(done_e), .tx_busy(busy_e));

  uart_tx_top #(.parity(2'd1)) dut_o (
    .clk(clk), .rst(rst), .tx_start(tx_start_p), .din(din_p),
    .tick(tick_o), .tx(tx_o), .tx_done(done_o), .tx_busy(busy_o));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consume n ticks (each seen at a negedge, acted on at the next posedge),
  // leaving time just after the posedge that used the last one.
  task automatic wait_ticks(input int n);
    int seen  = 0;
    int guard = 0;
    while (seen < n && guard < n * 400 + 10) begin
      @(negedge clk);
      guard++;
      if (tick) seen++;
    end
    @(posedge clk);
    #1;
    if (seen < n) chk("tick_timeout", 32'(seen), 32'(n));
  endtask

  task automatic start_dut(input logic [7:0] d);
    int g = 0;
    din      = d;
    tx_start = 1'b1;
    do begin
      @(posedge clk); #1; g++;
    end while (!tx_busy && g < 10);
    tx_start = 1'b0;
    chk("start_busy", 32'(tx_busy), 32'd1);
    chk("start_done_clr", 32'(tx_done), 32'd0);
    chk("start_tx", 32'(tx), 32'd0);
  endtask

  // Sample each bit mid-period; frame is start + 8 data + stop.
  task automatic check_frame(input string name, input logic [9:0] bits);
    for (int k = 0; k < 10; k++) begin
      wait_ticks(8);
      chk($sformatf("%s_bit%0d", name, k), 32'(tx), 32'(bits[k]));
      wait_ticks(8);
    end
    chk({name, "_done"}, 32'(tx_done), 32'd1);
    chk({name, "_busy"}, 32'(tx_busy), 32'd0);
    chk({name, "_tx"},   32'(tx), 32'd1);
    chk({name, "_st"},   32'(dut.state), 32'(DONE));
  endtask

  initial begin
    logic [7:0]  rnd;
    logic [10:0] ev_bits, od_bits;
    int          g, n;

    // Reset held for 10 clocks
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_tx",   32'(tx), 32'd1);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_st",   32'(dut.state), 32'(IDLE));
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_tx",   32'(tx), 32'd1);
    chk("idle_busy", 32'(tx_busy), 32'd0);

    // Frame 1: A5, no parity -> 0,1,0,1,0,0,1,0,1,1
    @(negedge clk);
    start_dut(8'hA5);
    check_frame("f1", 10'b11_0100_1010);

    // Frame 2 straight after, random data
    rnd = 8'($urandom_range(0, 255));
    start_dut(rnd);
    check_frame("f2", {1'b1, rnd, 1'b0});

    // Parity frames, din=07: even -> parity 1, odd -> parity 0, 176 ticks
    ev_bits = 11'b11_0000_0111_0;
    od_bits = 11'b10_0000_0111_0;
    din_p = 8'h07;
    tx_start_p = 1'b1;
    g = 0;
    do begin
      @(posedge clk); #1; g++;
    end while (!busy_e && g < 10);
    tx_start_p = 1'b0;
    chk("par_start_e", 32'(busy_e), 32'd1);
    chk("par_start_o", 32'(busy_o), 32'd1);
    for (int k = 0; k < 11; k++) begin
      wait_ticks(8);
      chk($sformatf("even_bit%0d", k), 32'(tx_e), 32'(ev_bits[k]));
      chk($sformatf("odd_bit%0d", k),  32'(tx_o), 32'(od_bits[k]));
      wait_ticks(8);
      if (k == 9) begin
        chk("par160_done_e", 32'(done_e), 32'd0);
        chk("par160_busy_e", 32'(busy_e), 32'd1);
      end
    end
    chk("par176_done_e", 32'(done_e), 32'd1);
    chk("par176_done_o", 32'(done_o), 32'd1);
    chk("par176_busy_o", 32'(busy_o), 32'd0);
    chk("par176_tx_e",   32'(tx_e), 32'd1);

    // Reset in the middle of a frame with tx_start held high
    din      = 8'h3C;
    tx_start = 1'b1;
    g = 0;
    do begin
      @(posedge clk); #1; g++;
    end while (!tx_busy && g < 10);
    chk("mid_start", 32'(tx_busy), 32'd1);
    wait_ticks(80);
    chk("mid_st",  32'(dut.state), 32'(DATA));
    chk("mid_bi",  32'(dut.bit_index), 32'd4);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_tx",   32'(tx), 32'd1);
    chk("abort_done", 32'(tx_done), 32'd0);
    chk("abort_busy", 32'(tx_busy), 32'd0);
    chk("abort_bi",   32'(dut.bit_index), 32'd0);
    chk("abort_tc",   32'(dut.tick_count), 32'd0);
    chk("abort_st",   32'(dut.state), 32'(IDLE));
    tx_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_abort_st", 32'(dut.state), 32'(IDLE));
    chk("post_abort_tx", 32'(tx), 32'd1);

    // Tick spacing and width
    for (int r = 0; r < 2; r++) begin
      g = 0;
      do begin
        @(negedge clk); g++;
      end while (!tick && g < 1000);
      chk("tick_found", 32'(tick), 32'd1);
      @(negedge clk);
      chk("tick_width", 32'(tick), 32'd0);
      n = 1;
      while (!tick && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk("tick_period", 32'(n), 32'd325);
      chk("tick_e_align", 32'(tick_e), 32'(tick));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
